// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v raster counters and
// registered sync/display/coordinate/strobe outputs, all aligned to one clock.
module vga_timing_gen #(
    parameter int unsigned CW       = 12,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          h_sync,
    output logic          v_sync,
    output logic          display,
    output logic          pix_stb,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          pix_en, h_wrap, v_wrap;

    logic [CW-1:0] x_q, y_q;
    logic          h_sync_q, v_sync_q, display_q;
    logic          pix_stb_q, line_start_q, frame_start_q;
    logic          h_sync_d, v_sync_d, display_d;

    // Window compares in 32 bits so a total of exactly 2^CW still decodes correctly.
    logic [31:0] h_ext, v_ext;

    always_comb begin
        pix_en        = (div_cnt_q == DIV_LAST);
        h_wrap        = (h_cnt_q == H_LAST);
        v_wrap        = (v_cnt_q == V_LAST);
        div_cnt_d     = pix_en ? '0 : div_cnt_q + DW'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        if (pix_en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + CW'(1);
                if (v_wrap) begin
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        h_ext     = 32'(h_cnt_q);
        v_ext     = 32'(v_cnt_q);
        display_d = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        h_sync_d  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
        v_sync_d  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
            display_q     <= 1'b0;
            h_sync_q      <= ~HS_POL;
            v_sync_q      <= ~VS_POL;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            pix_stb_q     <= pix_en;
            line_start_q  <= pix_en && (h_cnt_q == '0);
            frame_start_q <= pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
            // Presented pixel reflects the pre-increment counters.
            if (pix_en) begin
                x_q       <= h_cnt_q;
                y_q       <= v_cnt_q;
                display_q <= display_d;
                h_sync_q  <= h_sync_d;
                v_sync_q  <= v_sync_d;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign display     = display_q;
    assign pix_stb     = pix_stb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (div 1, div 4, positive polarity)
// checked against a per-cycle reference queue plus directed boundary checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        stb;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic        hs_a, vs_a, disp_a, stb_a, ls_a, fs_a;
    logic        hs_b, vs_b, disp_b, stb_b, ls_b, fs_b;
    logic        hs_c, vs_c, disp_c, stb_c, ls_c, fs_c;
    logic [7:0]  fc_a, fc_b, fc_c;

    vga_timing_gen #(
        .CW(12), .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y(y_a), .h_sync(hs_a), .v_sync(vs_a),
        .display(disp_a), .pix_stb(stb_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_count(fc_a)
    );

    vga_timing_gen #(
        .CW(12), .CLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y(y_b), .h_sync(hs_b), .v_sync(vs_b),
        .display(disp_b), .pix_stb(stb_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_count(fc_b)
    );

    vga_timing_gen #(
        .CW(12), .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst), .x(x_c), .y(y_c), .h_sync(hs_c), .v_sync(vs_c),
        .display(disp_c), .pix_stb(stb_c), .line_start(ls_c), .frame_start(fs_c),
        .frame_count(fc_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs k clocks after reset release, from the pixel-index timing rule.
    function automatic out_t model(input int k, input int d, input int ha, input int hfp,
                                   input int hsy, input int hbp, input int va, input int vfp,
                                   input int vsy, input int vbp, input bit hpol, input bit vpol);
        out_t o;
        int   ht, vt, n, px, py;
        ht   = ha + hfp + hsy + hbp;
        vt   = va + vfp + vsy + vbp;
        o    = '0;
        o.hs = ~hpol;
        o.vs = ~vpol;
        if (k < d) return o;
        n      = k / d - 1;
        px     = n % ht;
        py     = (n / ht) % vt;
        o.x    = 12'(px);
        o.y    = 12'(py);
        o.disp = (px < ha) && (py < va);
        o.hs   = (px >= ha + hfp && px < ha + hfp + hsy) ? hpol : ~hpol;
        o.vs   = (py >= va + vfp && py < va + vfp + vsy) ? vpol : ~vpol;
        o.stb  = (k % d == 0);
        o.ls   = o.stb && (px == 0);
        o.fs   = o.ls && (py == 0);
        o.fc   = 8'((n + 1) / (ht * vt));
        return o;
    endfunction

    out_t q_a[$], q_b[$], q_c[$];
    int   k_rel = 0;

    always @(posedge clk) begin : sb_push
        int kn;
        kn = rst ? 0 : k_rel + 1;
        k_rel <= kn;
        q_a.push_back(model(kn, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0));
        q_b.push_back(model(kn, 4, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0));
        q_c.push_back(model(kn, 2, 16, 2, 4, 3, 10, 1, 2, 2, 1'b1, 1'b1));
    end

    always @(negedge clk) begin : sb_pop
        out_t obs;
        if (q_a.size() > 0) begin
            obs = {x_a, y_a, disp_a, hs_a, vs_a, stb_a, ls_a, fs_a, fc_a};
            check("sb_div1", 64'(obs), 64'(q_a.pop_front()));
        end
        if (q_b.size() > 0) begin
            obs = {x_b, y_b, disp_b, hs_b, vs_b, stb_b, ls_b, fs_b, fc_b};
            check("sb_div4", 64'(obs), 64'(q_b.pop_front()));
        end
        if (q_c.size() > 0) begin
            obs = {x_c, y_c, disp_c, hs_c, vs_c, stb_c, ls_c, fs_c, fc_c};
            check("sb_pol", 64'(obs), 64'(q_c.pop_front()));
        end
    end

    int e = 0;
    task automatic to_edge(input int target);
        while (e < target) begin
            @(negedge clk);
            e++;
        end
    endtask

    initial begin
        int   n_fs, last_fs, cyc, hs_cnt, vs_cnt, dp_cnt, lines;
        logic found;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_hs", 64'(hs_a), 64'(1));
        check("rst_vs", 64'(vs_a), 64'(1));
        check("rst_stb", 64'(stb_a), 64'(0));
        check("rst_disp", 64'(disp_a), 64'(0));
        check("rst_hs_pol", 64'(hs_c), 64'(0));
        rst = 1'b0;

        to_edge(1);
        check("e1_fs", 64'({stb_a, ls_a, fs_a, disp_a}), 64'(4'b1111));
        check("e1_xy", 64'({x_a, y_a}), 64'(0));
        to_edge(3);
        check("div4_idle_stb", 64'(stb_b), 64'(0));
        to_edge(4);
        check("div4_first", 64'({stb_b, fs_b, x_b}), 64'({2'b11, 12'd0}));
        check("e4_disp", 64'(disp_a), 64'(1));
        to_edge(5);
        check("e5_disp", 64'(disp_a), 64'(0));
        check("div4_stb_low", 64'(stb_b), 64'(0));
        to_edge(6);
        check("e6_hs", 64'(hs_a), 64'(0));
        to_edge(8);
        check("e8_hs", 64'({hs_a, disp_a, x_a}), 64'({2'b10, 12'd7}));
        to_edge(9);
        check("e9_wrap", 64'({ls_a, fs_a, x_a, y_a}), 64'({2'b10, 12'd0, 12'd1}));
        to_edge(33);
        check("e33_vs", 64'({vs_a, disp_a, y_a}), 64'({2'b00, 12'd4}));
        to_edge(41);
        check("e41_vs", 64'({vs_a, y_a}), 64'({1'b1, 12'd5}));
        to_edge(49);
        check("e49_frame", 64'({fs_a, fc_a}), 64'({1'b1, 8'd1}));

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (x_a == 12'd2 && y_a == 12'd1) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst_reached", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_a", 64'({x_a, y_a, fc_a, stb_a, hs_a}), 64'({32'd0, 2'b01}));
        check("midrst_fc_b", 64'(fc_b), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("midrst_e1_fs", 64'(fs_a), 64'(1));

        n_fs = 0; last_fs = 0; cyc = 0; hs_cnt = 0; vs_cnt = 0; dp_cnt = 0; lines = 0;
        while (n_fs < 3 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stb_c) begin
                if (fs_c) begin
                    if (n_fs > 0) begin
                        check("frame_period", 64'(cyc - last_fs), 64'(750));
                        check("vs_pixels", 64'(vs_cnt), 64'(50));
                        check("disp_pixels", 64'(dp_cnt), 64'(160));
                    end
                    n_fs++;
                    last_fs = cyc;
                    vs_cnt  = 0;
                    dp_cnt  = 0;
                end
                if (ls_c) begin
                    if (lines > 0) check("hs_per_line", 64'(hs_cnt), 64'(4));
                    lines++;
                    hs_cnt = 0;
                end
                if (hs_c) hs_cnt++;
                if (vs_c) vs_cnt++;
                if (disp_c) dp_cnt++;
            end
        end
        check("frames_seen", 64'(n_fs), 64'(3));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
